// File: rtl/bk_pkg.sv
// Shared types and elaboration helpers for the pipelined Brent-Kung adder.
// Level/group arithmetic lives here so the top and the bench agree on it.
package bk_pkg;

  typedef struct packed {
    logic g;
    logic p;
  } pg_t;

  function automatic int bk_levels(input int w);
    return 2 * $clog2(w) - 1;
  endfunction

  function automatic int bk_groups(input int w, input int r);
    return (bk_levels(w) + r - 1) / r;
  endfunction

  function automatic int bk_stage(input int lvl, input int r);
    return lvl / r;
  endfunction

  function automatic int bk_span(input int w, input int lvl);
    int n;
    n = $clog2(w);
    return (lvl < n) ? lvl + 1 : 2 * n - 1 - lvl;
  endfunction

  function automatic int bk_half(input int w, input int lvl);
    return 1 << (bk_span(w, lvl) - 1);
  endfunction

  function automatic logic bk_active(input int w, input int lvl,
                                     input int i);
    int m;
    m = 1 << bk_span(w, lvl);
    if (lvl < $clog2(w)) return ((i + 1) % m) == 0;
    return (((i + 1) % m) == (m / 2)) && (i + 1 > m);
  endfunction

endpackage

// File: rtl/bk_adder_pipe_cell.sv
// Brent-Kung prefix combine operator: (g,p) = (g1 | p1&g0, p1&p0).
// Instantiated only where a level actually merges two spans.
module bk_prefix_cell (
  input  logic g1,
  input  logic p1,
  input  logic g0,
  input  logic p0,
  output logic g,
  output logic p
);

  assign g = g1 | (p1 & g0);
  assign p = p1 & p0;

endmodule

// File: rtl/bk_adder_pipe.sv
// Pipelined Brent-Kung adder/subtractor with global-stall handshake.
// Define BK_ADDER_PIPE_OVF_EN to add the registered signed-overflow port.
module bk_adder_pipe
  import bk_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int REG_EVERY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] x2,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout
`ifdef BK_ADDER_PIPE_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int L = bk_levels(WIDTH);
  localparam int G = bk_groups(WIDTH, REG_EVERY);

  logic                   adv;
  logic [WIDTH-1:0]       b;
  logic [WIDTH-1:0]       p_in;
  logic                   c0_in;
  pg_t  [WIDTH-1:0]       pg_in;

  pg_t  [WIDTH-1:0]       st_pg   [G];
  logic [WIDTH-1:0]       st_p    [G];
  logic                   st_c0   [G];
  logic                   st_v    [G];
  pg_t  [WIDTH-1:0]       grp_out [G];

  pg_t  [WIDTH-1:0]       fin;
  logic [WIDTH-1:0]       s_d;
  logic                   cout_d;
  logic                   unused_fin;

  assign in_ready = !out_valid | out_ready;
  assign adv      = in_ready;

  // Operand conditioning; carry-in is folded into bit 0's generate.
  always_comb begin
    b     = sub ? ~x2 : x2;
    c0_in = sub ? ~cin : cin;
    p_in  = x1 ^ b;
    for (int i = 0; i < WIDTH; i++) begin
      pg_in[i].g = x1[i] & b[i];
      pg_in[i].p = p_in[i];
    end
    pg_in[0].g = pg_in[0].g | (p_in[0] & c0_in);
  end

  for (genvar j = 0; j < L; j++) begin : lv
    pg_t [WIDTH-1:0] din;
    pg_t [WIDTH-1:0] dout;

    if (j % REG_EVERY == 0) begin : g_reg
      assign din = st_pg[bk_stage(j, REG_EVERY)];
    end else begin : g_comb
      assign din = lv[j-1].dout;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : gb
      if (bk_active(WIDTH, j, i)) begin : g_cell
        bk_prefix_cell u_cell (
          .g1 (din[i].g),
          .p1 (din[i].p),
          .g0 (din[i - bk_half(WIDTH, j)].g),
          .p0 (din[i - bk_half(WIDTH, j)].p),
          .g  (dout[i].g),
          .p  (dout[i].p)
        );
      end else begin : g_pass
        assign dout[i] = din[i];
      end
    end

    if (((j + 1) % REG_EVERY == 0) || (j == L - 1)) begin : g_tap
      assign grp_out[bk_stage(j, REG_EVERY)] = dout;
    end
  end

  assign fin        = grp_out[G-1];
  assign unused_fin = ^fin;

  // Sum bits from the final group prefixes and the original propagates.
  always_comb begin
    s_d    = '0;
    s_d[0] = st_p[G-1][0] ^ st_c0[G-1];
    for (int i = 1; i < WIDTH; i++) begin
      s_d[i] = st_p[G-1][i] ^ fin[i-1].g;
    end
    cout_d = fin[WIDTH-1].g;
  end

  // All stages shift together on adv; bubbles travel as cleared valids.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < G; r++) begin
        st_pg[r] <= '0;
        st_p[r]  <= '0;
        st_c0[r] <= 1'b0;
        st_v[r]  <= 1'b0;
      end
      out_valid <= 1'b0;
      s         <= '0;
      cout      <= 1'b0;
`ifdef BK_ADDER_PIPE_OVF_EN
      ovf       <= 1'b0;
`endif
    end else if (adv) begin
      st_pg[0] <= pg_in;
      st_p[0]  <= p_in;
      st_c0[0] <= c0_in;
      st_v[0]  <= in_valid;
      for (int r = 1; r < G; r++) begin
        st_pg[r] <= grp_out[r-1];
        st_p[r]  <= st_p[r-1];
        st_c0[r] <= st_c0[r-1];
        st_v[r]  <= st_v[r-1];
      end
      out_valid <= st_v[G-1];
      s         <= s_d;
      cout      <= cout_d;
`ifdef BK_ADDER_PIPE_OVF_EN
      ovf       <= fin[WIDTH-1].g ^ fin[WIDTH-2].g;
`endif
    end
  end

endmodule

// File: tb/tb_bk_adder_pipe.sv
// Directed checks for bk_adder_pipe: table vectors, streaming, stall,
// and two extra geometries (4-bit/R1 and 64-bit/R7).
module tb_bk_adder_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        rst_n, in_valid, in_ready, cin, sub;
  logic        out_valid, out_ready, cout;
  logic [15:0] x1, x2, s;
`ifdef BK_ADDER_PIPE_OVF_EN
  logic        ovf;
  logic        a_ovf, b_ovf;
`endif

  logic        a_iv, a_ir, a_cin, a_sub, a_ov, a_or, a_co;
  logic [3:0]  a_x1, a_x2, a_s;
  logic        b_iv, b_ir, b_cin, b_sub, b_ov, b_or, b_co;
  logic [63:0] b_x1, b_x2, b_s;

  bk_adder_pipe #(.WIDTH(16), .REG_EVERY(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x1(x1), .x2(x2), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .s(s), .cout(cout)
`ifdef BK_ADDER_PIPE_OVF_EN
    , .ovf(ovf)
`endif
  );

  bk_adder_pipe #(.WIDTH(4), .REG_EVERY(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_iv), .in_ready(a_ir),
    .x1(a_x1), .x2(a_x2), .cin(a_cin), .sub(a_sub), .out_valid(a_ov),
    .out_ready(a_or), .s(a_s), .cout(a_co)
`ifdef BK_ADDER_PIPE_OVF_EN
    , .ovf(a_ovf)
`endif
  );

  bk_adder_pipe #(.WIDTH(64), .REG_EVERY(7)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_iv), .in_ready(b_ir),
    .x1(b_x1), .x2(b_x2), .cin(b_cin), .sub(b_sub), .out_valid(b_ov),
    .out_ready(b_or), .s(b_s), .cout(b_co)
`ifdef BK_ADDER_PIPE_OVF_EN
    , .ovf(b_ovf)
`endif
  );

  typedef struct {
    logic [15:0] x1;
    logic [15:0] x2;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t        tv [10];
  logic [15:0] vx1 [140];
  logic [15:0] vx2 [140];
  logic        vcin [140];
  logic        vsub [140];
  logic [65:0] q [$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference: {ovf, cout, s} from plain wide arithmetic.
  function automatic logic [65:0] ref_op(input int w, input logic [63:0] a,
                                         input logic [63:0] bi,
                                         input logic c, input logic sb);
    logic [63:0] mask, am, bm;
    logic [64:0] sum;
    logic        cc, co, ov;
    mask = (64'd1 << w) - 64'd1;
    if (w == 64) mask = '1;
    am  = a & mask;
    bm  = (sb ? ~bi : bi) & mask;
    cc  = sb ? ~c : c;
    sum = {1'b0, am} + {1'b0, bm} + {64'd0, cc};
    co  = sum[w];
    ov  = (am[w-1] == bm[w-1]) && (sum[w-1] != am[w-1]);
    return {ov, co, sum[63:0] & mask};
  endfunction

  task automatic run_vec(input vec_t v, input string nm);
    int n;
    @(negedge clk);
    x1 = v.x1; x2 = v.x2; cin = v.cin; sub = v.sub;
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_lat"}, 64'(n), 64'd5);
    chk({nm, "_s"}, 64'(s), 64'(v.s));
    chk({nm, "_cout"}, 64'(cout), 64'(v.cout));
`ifdef BK_ADDER_PIPE_OVF_EN
    chk({nm, "_ovf"}, 64'(ovf), 64'(v.ovf));
`endif
    @(negedge clk);
    chk({nm, "_once"}, 64'(out_valid), 64'd0);
  endtask

  task automatic stream(input int first, input int cnt, input int stall_at,
                        output int t_in, output int t_out,
                        output int t_last, output int got);
    int          idx, t, sc;
    bit          stalled;
    logic [15:0] ss;
    logic        sco;
    logic [65:0] e;
    idx = first; got = 0; t = 0; sc = 0; stalled = 0;
    t_in = -1; t_out = -1; t_last = -1;
    ss = '0; sco = 1'b0;
    while (got < cnt && t < 1000) begin
      @(negedge clk);
      if (!stalled && stall_at >= 0 && got == stall_at && out_valid) begin
        stalled = 1; sc = 7; ss = s; sco = cout;
      end
      out_ready = (sc == 0);
      in_valid  = (idx < first + cnt);
      if (in_valid) begin
        x1 = vx1[idx]; x2 = vx2[idx]; cin = vcin[idx]; sub = vsub[idx];
      end
      #1;
      if (sc > 0) begin
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        if (sc < 7) begin
          chk("stall_valid", 64'(out_valid), 64'd1);
          chk("stall_s", 64'(s), 64'(ss));
          chk("stall_cout", 64'(cout), 64'(sco));
        end
        sc--;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("stream_extra", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          chk("stream_s", 64'(s), e[63:0]);
          chk("stream_cout", 64'(cout), 64'(e[64]));
`ifdef BK_ADDER_PIPE_OVF_EN
          chk("stream_ovf", 64'(ovf), 64'(e[65]));
`endif
        end
        if (t_out < 0) t_out = t;
        t_last = t;
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_op(16, 64'(vx1[idx]), 64'(vx2[idx]),
                           vcin[idx], vsub[idx]));
        if (t_in < 0) t_in = t;
        idx++;
      end
      t++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int ti, to, tl, got, n;
    logic [65:0] r;

    tv[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    tv[1] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    tv[2] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    tv[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    tv[4] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
    tv[5] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};
    tv[6] = '{16'h0003, 16'h0003, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    tv[7] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    tv[8] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    tv[9] = '{16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};

    for (int i = 0; i < 140; i++) begin
      vx1[i]  = 16'($urandom);
      vx2[i]  = 16'($urandom);
      vcin[i] = 1'($urandom);
      vsub[i] = 1'($urandom);
    end

    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    x1 = 16'h1234; x2 = 16'h1111; cin = 1'b0; sub = 1'b0;
    a_iv = 1'b0; a_or = 1'b1; a_x1 = '0; a_x2 = '0; a_cin = 0; a_sub = 0;
    b_iv = 1'b0; b_or = 1'b1; b_x1 = '0; b_x2 = '0; b_cin = 0; b_sub = 0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_s", 64'(s), 64'd0);
      chk("rst_cout", 64'(cout), 64'd0);
`ifdef BK_ADDER_PIPE_OVF_EN
      chk("rst_ovf", 64'(ovf), 64'd0);
`endif
    end
    in_valid = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_vec(tv[i], $sformatf("vec%0d", i));
    end

    stream(0, 100, -1, ti, to, tl, got);
    chk("thru_count", 64'(got), 64'd100);
    chk("thru_first_lat", 64'(to - ti), 64'd5);
    chk("thru_back_to_back", 64'(tl - to), 64'd99);
    chk("thru_drained", 64'(q.size()), 64'd0);

    stream(100, 40, 15, ti, to, tl, got);
    chk("bp_count", 64'(got), 64'd40);
    chk("bp_drained", 64'(q.size()), 64'd0);
    chk("bp_stretch", 64'(tl - to), 64'd46);

    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      a_x1 = 4'($urandom); a_x2 = 4'($urandom);
      a_cin = 1'($urandom); a_sub = 1'($urandom);
      a_iv = 1'b1;
      @(negedge clk);
      a_iv = 1'b0;
      n = 1;
      while (!a_ov && n < 20) begin
        @(negedge clk);
        n++;
      end
      r = ref_op(4, 64'(a_x1), 64'(a_x2), a_cin, a_sub);
      chk("w4_lat", 64'(n), 64'd4);
      chk("w4_s", 64'(a_s), r[63:0]);
      chk("w4_cout", 64'(a_co), 64'(r[64]));
`ifdef BK_ADDER_PIPE_OVF_EN
      chk("w4_ovf", 64'(a_ovf), 64'(r[65]));
`endif
    end

    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      b_x1 = {$urandom, $urandom}; b_x2 = {$urandom, $urandom};
      if (k == 0) begin b_x1 = '1; b_x2 = 64'd1; end
      b_cin = 1'($urandom); b_sub = 1'($urandom);
      b_iv = 1'b1;
      @(negedge clk);
      b_iv = 1'b0;
      n = 1;
      while (!b_ov && n < 20) begin
        @(negedge clk);
        n++;
      end
      r = ref_op(64, b_x1, b_x2, b_cin, b_sub);
      chk("w64_lat", 64'(n), 64'd3);
      chk("w64_s", b_s, r[63:0]);
      chk("w64_cout", 64'(b_co), 64'(r[64]));
`ifdef BK_ADDER_PIPE_OVF_EN
      chk("w64_ovf", 64'(b_ovf), 64'(r[65]));
`endif
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
